// File: rtl/sp701_fir_top.sv
// sp701_fir_top
//   Board-level top of the SP701 AXI4-Stream FIR demonstrator: a deterministic
//   test-signal source feeds an 8-tap fixed-coefficient FIR whose master port
//   drains into an always-ready sink. Filter results are brought out for
//   simulation and ILA observation.
//
// Parameters
//   STIM_MODE   : 0 = single impulse, 1 = square wave
//   AMP         : source amplitude (signed 16-bit, positive)
//   HALF_PERIOD : square-wave half period in samples (>=1)
//   SAMPLE_DIV  : clocks per source sample (>=2)
//
// Ports
//   sys_diff_clock_clk_p : positive clock leg, all logic on its rising edge
//   sys_diff_clock_clk_n : negative clock leg (complement only, unused here)
//   reset                : asynchronous active-low reset button
//   fir_tdata            : registered signed FIR output sample
//   fir_tvalid           : one-clock pulse per FIR output sample
//   src_tdata            : signed source sample currently offered to the FIR
module sp701_fir_top #(
    parameter int STIM_MODE   = 1,
    parameter int AMP         = 1000,
    parameter int HALF_PERIOD = 16,
    parameter int SAMPLE_DIV  = 4
) (
    input  logic        sys_diff_clock_clk_p,
    input  logic        sys_diff_clock_clk_n,
    input  logic        reset,
    output logic [31:0] fir_tdata,
    output logic        fir_tvalid,
    output logic [15:0] src_tdata
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 8;
    localparam int STAGES = 8;
    localparam int ACC_W  = DATA_W + COEF_W + 3;
    localparam int OUT_W  = 32;
    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [DIV_W-1:0]         DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [31:0]              HP_LAST  = 32'(HALF_PERIOD - 1);
    localparam logic signed [DATA_W-1:0] AMP_POS  = DATA_W'(AMP);
    localparam logic signed [DATA_W-1:0] AMP_NEG  = -AMP_POS;

    logic clk;
    logic unused_clk_n;

    // The differential pair is resolved by an IBUFDS on hardware; here only
    // the positive leg is needed.
    assign clk          = sys_diff_clock_clk_p;
    assign unused_clk_n = sys_diff_clock_clk_n;

    function automatic logic signed [COEF_W-1:0] coef(input int i);
        case (i)
            0:       coef = 8'sd1;
            1:       coef = 8'sd2;
            2:       coef = 8'sd3;
            3:       coef = 8'sd4;
            4:       coef = 8'sd4;
            5:       coef = 8'sd3;
            6:       coef = 8'sd2;
            default: coef = 8'sd1;
        endcase
    endfunction

    // Full-precision signed product, already widened to accumulator width.
    function automatic logic signed [ACC_W-1:0] mul_tap(
        input logic signed [DATA_W-1:0] x,
        input logic signed [COEF_W-1:0] c
    );
        logic signed [ACC_W-1:0] xe;
        logic signed [ACC_W-1:0] ce;
        xe = $signed({{(ACC_W - DATA_W){x[DATA_W-1]}}, x});
        ce = $signed({{(ACC_W - COEF_W){c[COEF_W-1]}}, c});
        mul_tap = xe * ce;
    endfunction

    function automatic logic signed [OUT_W-1:0] sext_out(input logic signed [ACC_W-1:0] a);
        sext_out = $signed({{(OUT_W - ACC_W){a[ACC_W-1]}}, a});
    endfunction

    // Reset: asserts asynchronously, releases two clocks after the button.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // Stage p0: test-signal source and handshake
    logic [DIV_W-1:0]         div_cnt;
    logic [31:0]              idx;
    logic [31:0]              hp_cnt;
    logic                     phase;
    logic signed [DATA_W-1:0] x_cur;
    logic signed [DATA_W-1:0] src_p0;
    logic                     src_tvalid;
    logic                     s_tready;
    logic                     m_tready;
    logic                     vld_p0;
    logic                     vld_p1;

    assign m_tready   = 1'b1;
    assign src_tvalid = (div_cnt == DIV_LAST);
    assign s_tready   = !vld_p1 || m_tready;
    assign vld_p0     = src_tvalid && s_tready;

    always_comb begin
        x_cur = (STIM_MODE == 0) ? ((idx == 32'd0) ? AMP_POS : '0)
                                 : (phase ? AMP_NEG : AMP_POS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
            hp_cnt  <= '0;
            phase   <= 1'b0;
            src_p0  <= '0;
        end else begin
            // The divider parks on its last count while the offer is refused,
            // which keeps tvalid asserted until acceptance.
            if (!(src_tvalid && !s_tready)) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            end
            // Index and phase only move on a transfer, so this holds tdata
            // stable while an offer is pending.
            src_p0 <= x_cur;
            if (vld_p0) begin
                idx <= idx + 32'd1;
                // On index wrap floor(n/HALF_PERIOD) restarts at zero.
                if (idx == 32'hFFFF_FFFF) begin
                    hp_cnt <= '0;
                    phase  <= 1'b0;
                end else if (hp_cnt == HP_LAST) begin
                    hp_cnt <= '0;
                    phase  <= ~phase;
                end else begin
                    hp_cnt <= hp_cnt + 32'd1;
                end
            end
        end
    end

    // Stage p1: FIR delay line and registered result
    logic signed [DATA_W-1:0] hist_p0 [STAGES-1];
    logic signed [ACC_W-1:0]  acc;
    logic signed [OUT_W-1:0]  fir_p1;

    // The incoming sample acts as tap 0; hist_p0 holds x[n-1]..x[n-7].
    always_comb begin
        acc = mul_tap(src_p0, coef(0));
        for (int i = 1; i < STAGES; i++) begin
            acc = acc + mul_tap(hist_p0[i-1], coef(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES - 1; i++) begin
                hist_p0[i] <= '0;
            end
            fir_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            if (vld_p0) begin
                hist_p0[0] <= src_p0;
                for (int i = 1; i < STAGES - 1; i++) begin
                    hist_p0[i] <= hist_p0[i-1];
                end
                fir_p1 <= sext_out(acc);
            end
            vld_p1 <= vld_p0 || (vld_p1 && !m_tready);
        end
    end

    assign fir_tdata  = fir_p1;
    assign fir_tvalid = vld_p1;
    assign src_tdata  = src_p0;

endmodule

// File: tb/tb_sp701_fir_top.sv
module tb_sp701_fir_top;

    localparam int SD_IMP = 4;
    localparam int SD_SQ  = 2;

    logic        clk_p = 1'b0;
    logic        clk_n;
    logic        rst_n;
    logic [31:0] imp_tdata;
    logic [31:0] sq_tdata;
    logic        imp_tvalid;
    logic        sq_tvalid;
    logic [15:0] imp_src;
    logic [15:0] sq_src;

    always #5 clk_p = ~clk_p;
    assign clk_n = ~clk_p;

    sp701_fir_top #(.STIM_MODE(0), .AMP(1000), .HALF_PERIOD(16), .SAMPLE_DIV(SD_IMP)) dut_imp (
        .sys_diff_clock_clk_p(clk_p),
        .sys_diff_clock_clk_n(clk_n),
        .reset(rst_n),
        .fir_tdata(imp_tdata),
        .fir_tvalid(imp_tvalid),
        .src_tdata(imp_src)
    );

    sp701_fir_top #(.STIM_MODE(1), .AMP(1000), .HALF_PERIOD(16), .SAMPLE_DIV(SD_SQ)) dut_sq (
        .sys_diff_clock_clk_p(clk_p),
        .sys_diff_clock_clk_n(clk_n),
        .reset(rst_n),
        .fir_tdata(sq_tdata),
        .fir_tvalid(sq_tvalid),
        .src_tdata(sq_src)
    );

    int n_checks = 0;
    int n_errors = 0;
    int q_imp[$];
    int q_sq[$];
    bit armed_imp = 1'b0;
    bit armed_sq  = 1'b0;
    bit seen_imp  = 1'b0;
    bit seen_sq   = 1'b0;
    int gap_imp   = 0;
    int gap_sq    = 0;

    int H[8]       = '{1, 2, 3, 4, 4, 3, 2, 1};
    int IMP_EXP[8] = '{1000, 2000, 3000, 4000, 4000, 3000, 2000, 1000};
    int SQ_RAMP[8] = '{1000, 3000, 6000, 10000, 14000, 17000, 19000, 20000};

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sq_x(input int k);
        return (((k / 16) % 2) == 0) ? 1000 : -1000;
    endfunction

    function automatic int sq_model(input int n);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            if (n - i >= 0) s += H[i] * sq_x(n - i);
        end
        return s;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_imp_tdata"},  imp_tdata,  0);
        chk({tag, "_imp_tvalid"}, imp_tvalid, 0);
        chk({tag, "_imp_src"},    imp_src,    0);
        chk({tag, "_sq_tdata"},   sq_tdata,   0);
        chk({tag, "_sq_tvalid"},  sq_tvalid,  0);
        chk({tag, "_sq_src"},     sq_src,     0);
    endtask

    // Queue the expected responses, then release reset between clock edges.
    task automatic release_reset(input int n_imp, input int n_sq);
        @(negedge clk_p);
        #2;
        q_imp.delete();
        q_sq.delete();
        for (int i = 0; i < n_imp; i++) q_imp.push_back((i < 8) ? IMP_EXP[i] : 0);
        for (int i = 0; i < n_sq; i++)  q_sq.push_back((i < 8) ? SQ_RAMP[i] : sq_model(i));
        gap_imp   = 0;
        gap_sq    = 0;
        seen_imp  = 1'b0;
        seen_sq   = 1'b0;
        armed_imp = 1'b1;
        armed_sq  = 1'b1;
        rst_n     = 1'b1;
    endtask

    task automatic wait_done(input int limit);
        for (int c = 0; c < limit && (armed_imp || armed_sq); c++) @(negedge clk_p);
        chk("outputs_drained_in_time", (armed_imp || armed_sq), 0);
    endtask

    // Monitor: pops and compares whenever a DUT presents an output.
    always @(negedge clk_p) begin
        if (armed_imp) begin
            gap_imp++;
            if (imp_tvalid) begin
                if (seen_imp) chk("imp_pulse_spacing", gap_imp, SD_IMP);
                else chk("imp_first_pulse_window", (gap_imp >= SD_IMP && gap_imp <= SD_IMP + 3), 1);
                seen_imp = 1'b1;
                gap_imp  = 0;
                chk("imp_tdata", $signed(imp_tdata), q_imp.pop_front());
                if (q_imp.size() == 0) armed_imp = 1'b0;
            end
        end
        if (armed_sq) begin
            gap_sq++;
            if (sq_tvalid) begin
                if (seen_sq) chk("sq_pulse_spacing", gap_sq, SD_SQ);
                else chk("sq_first_pulse_window", (gap_sq >= SD_SQ && gap_sq <= SD_SQ + 3), 1);
                seen_sq = 1'b1;
                gap_sq  = 0;
                chk("sq_tdata", $signed(sq_tdata), q_sq.pop_front());
                if (q_sq.size() == 0) armed_sq = 1'b0;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        // 40 ns of reset at 100 MHz: everything reads zero.
        repeat (4) begin
            @(negedge clk_p);
            check_idle("reset");
        end

        // Impulse response then zeros; square wave over several periods.
        release_reset(20, 200);
        wait_done(3000);

        // Asynchronous reset in the middle of the square wave.
        @(posedge clk_p);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        repeat (3) begin
            @(negedge clk_p);
            check_idle("mid_reset");
        end

        // After release the sequences restart from n=0.
        release_reset(20, 40);
        wait_done(2000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
